// File: rtl/counter_mod_n_pkg.sv
// Shared constants and helpers for the modulo-N counter family.
// Imported by counter_mod_n and counter_prescaler.
package counter_mod_n_pkg;

  localparam int unsigned DEFAULT_MOD_N = 100;

  localparam logic COUNT_UP = 1'b1;
  localparam logic COUNT_DN = 1'b0;

  // Ceiling log2 with a floor of 1 bit, so degenerate sizes still give a usable vector.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Step-enable generator: o_step is high one clock in every PRESCALE clocks.
// Only compiled when COUNTER_MOD_N_PRESCALE_EN is defined.
`ifdef COUNTER_MOD_N_PRESCALE_EN
module counter_prescaler
  import counter_mod_n_pkg::*;
#(
  parameter int unsigned PRESCALE = 10
) (
  input  logic clk,
  input  logic reset_n,
  output logic o_step
);

  localparam int unsigned PhW = clog2(PRESCALE);
  localparam logic [PhW-1:0] PhLast = PhW'(PRESCALE - 1);
  localparam logic [PhW-1:0] PhOne = PhW'(1);

  logic [PhW-1:0] phase_q;
  logic [PhW-1:0] phase_d;

  always_comb begin
    o_step  = (phase_q == PhLast);
    phase_d = o_step ? '0 : phase_q + PhOne;
  end

  // Phase free-runs; only reset_n can realign it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule
`endif

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter with clear, load, terminal-count pulse and a free-running twin.
// Define COUNTER_MOD_N_PRESCALE_EN to advance both counts once every PRESCALE clocks.
module counter_mod_n
  import counter_mod_n_pkg::*;
#(
  parameter int unsigned MOD_N    = DEFAULT_MOD_N,
  parameter int unsigned CNT_W    = clog2(MOD_N),
  parameter int unsigned PRESCALE = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_up,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_always,
  output logic             o_tc
);

  if (MOD_N < 2) begin : g_bad_mod_n
    $error("counter_mod_n: MOD_N must be at least 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("counter_mod_n: PRESCALE must be at least 1");
  end
  if (CNT_W < clog2(MOD_N)) begin : g_bad_cnt_w
    $error("counter_mod_n: CNT_W too narrow for MOD_N");
  end

  // One spare bit keeps +1/-1 and the load compare free of wrap-around aliasing.
  localparam logic [CNT_W:0] MaxVal = (CNT_W + 1)'(MOD_N - 1);
  localparam logic [CNT_W:0] One    = (CNT_W + 1)'(1);

  logic step;

`ifdef COUNTER_MOD_N_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset_n(reset_n),
    .o_step (step)
  );
`else
  assign step = 1'b1;
`endif

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_always_q;
  logic [CNT_W-1:0] cnt_always_d;
  logic             tc_q;
  logic             tc_d;

  logic [CNT_W:0] cnt_ext;
  logic [CNT_W:0] cnt_inc;
  logic [CNT_W:0] cnt_dec;
  logic [CNT_W:0] load_ext;
  logic [CNT_W:0] load_sat;
  logic [CNT_W:0] always_ext;
  logic [CNT_W:0] always_inc;
  logic           at_max;
  logic           at_zero;

  always_comb begin
    cnt_ext    = {1'b0, cnt_q};
    at_max     = (cnt_ext == MaxVal);
    at_zero    = (cnt_ext == '0);
    cnt_inc    = at_max ? '0 : cnt_ext + One;
    cnt_dec    = at_zero ? MaxVal : cnt_ext - One;
    load_ext   = {1'b0, i_load_val};
    load_sat   = (load_ext > MaxVal) ? MaxVal : load_ext;
    always_ext = {1'b0, cnt_always_q};
    always_inc = (always_ext == MaxVal) ? '0 : always_ext + One;
  end

  // Gated count and its terminal-count pulse: clear > load > step > hold.
  always_comb begin
    cnt_d = cnt_q;
    tc_d  = 1'b0;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = CNT_W'(load_sat);
    end else if (i_en && step) begin
      case (i_up)
        COUNT_UP: begin
          cnt_d = CNT_W'(cnt_inc);
          tc_d  = at_max;
        end
        COUNT_DN: begin
          cnt_d = CNT_W'(cnt_dec);
          tc_d  = at_zero;
        end
      endcase
    end
  end

  always_comb begin
    cnt_always_d = step ? CNT_W'(always_inc) : cnt_always_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_always_q <= '0;
    end else begin
      cnt_always_q <= cnt_always_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tc_q <= 1'b0;
    end else begin
      tc_q <= tc_d;
    end
  end

  assign o_cnt        = cnt_q;
  assign o_cnt_always = cnt_always_q;
  assign o_tc         = tc_q;

  // Wrap-by-compare must keep both counts inside 0..MOD_N-1.
  cnt_range_a : assert property (@(posedge clk) disable iff (!reset_n)
      (32'(cnt_q) < MOD_N));
  cnt_always_range_a : assert property (@(posedge clk) disable iff (!reset_n)
      (32'(cnt_always_q) < MOD_N));

endmodule
